// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the IF/MEM RAM port arbiter: FSM state encoding,
//   latency bounds and default bus widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2
    } arb_state_e;

    // Largest supported RAM_LATENCY and the counter width that holds it.
    localparam int ARB_MAX_LATENCY = 4;
    localparam int ARB_LAT_W       = 3;

    // Width of the starvation counter.
    localparam int ARB_STARVE_W    = 4;

    // Default address/data widths of the core.
    localparam int ARB_ADDR_WIDTH  = 32;
    localparam int ARB_DATA_WIDTH  = 32;

endpackage

// File: rtl/mem_port_arbiter_lat.sv
// arb_lat_timer
//   Loadable down-counter that tracks the RAM read latency of the single
//   outstanding access.
//   Ports:
//     clk_i, rst_i  : clock, synchronous active-high reset
//     load_i        : load load_val_i (grant cycle)
//     load_val_i    : latency to load
//     dec_i         : decrement (a transaction is outstanding)
//     done_o        : combinational; high in the cycle the count reaches 0,
//                     i.e. the cycle in which ram_rdata_i is valid
module arb_lat_timer
    import mem_port_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [ARB_LAT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 done_o
);

    logic [ARB_LAT_W-1:0] cnt_q;
    logic [ARB_LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ARB_LAT_W'(1);
        end
    end

    // The decrement from 1 to 0 marks the data-valid cycle.
    assign done_o = dec_i && (cnt_q == ARB_LAT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM between instruction fetch (IF) and the memory
//   stage (MEM). One access is outstanding at a time; each access returns a
//   one-cycle rvalid pulse RAM_LATENCY+1 cycles after its grant.
//   Ports:
//     clk_i, rst_i            : clock, synchronous active-high reset
//     if_*                    : fetch request / grant / response
//     mem_*                   : data request (read or byte-enabled write) / grant / response
//     ram_*                   : RAM command (valid only in the grant cycle) and read data
//     stallreq_if_o/_mem_o    : x_req_i & ~x_rvalid_o, independent of grant
//     dbg_state_o             : current FSM state
//   Optional feature (macro MEM_PORT_ARB_PERF_CNT_EN): adds if_grant_cnt_o,
//   mem_grant_cnt_o and conflict_cnt_o, 32-bit wrapping event counters.
//   Handshake: a requester holds req and its fields stable from assertion up
//   to and including its rvalid cycle; req still high in the rvalid cycle is
//   treated as the next request and may be granted in that same cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int RAM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_be_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_gnt_o,
    output logic                  mem_rvalid_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  stallreq_if_o,
    output logic                  stallreq_mem_o,
    output arb_state_e            dbg_state_o
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           if_grant_cnt_o,
    output logic [31:0]           mem_grant_cnt_o,
    output logic [31:0]           conflict_cnt_o
`endif
);

    localparam logic [ARB_STARVE_W-1:0] STARVE_LIM = ARB_STARVE_W'(STARVE_LIMIT);
    localparam logic [ARB_LAT_W-1:0]    LAT_LOAD   = ARB_LAT_W'(RAM_LATENCY);

    arb_state_e              state_q;
    logic [ARB_STARVE_W-1:0] starve_q;
    logic                    mem_we_q;
    logic                    if_rvalid_q;
    logic                    mem_rvalid_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic [DATA_WIDTH-1:0]   mem_rdata_q;
    logic                    if_win;
    logic                    mem_win;
    logic                    lat_done;

    // Arbitration only happens in IDLE; MEM wins unless IF has been starved.
    always_comb begin
        if_win  = 1'b0;
        mem_win = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (if_req_i && (!mem_req_i || (starve_q == STARVE_LIM))) begin
                if_win = 1'b1;
            end else if (mem_req_i) begin
                mem_win = 1'b1;
            end
        end
    end

    // RAM command is driven only in the grant cycle; zero otherwise.
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (mem_win) begin
            ram_ce_o    = 1'b1;
            ram_we_o    = mem_we_i;
            ram_be_o    = mem_be_i;
            ram_addr_o  = mem_addr_i;
            ram_wdata_o = mem_wdata_i;
        end else if (if_win) begin
            ram_ce_o    = 1'b1;
            ram_addr_o  = if_addr_i;
        end
    end

    arb_lat_timer u_lat_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (if_win || mem_win),
        .load_val_i (LAT_LOAD),
        .dec_i      (state_q != ARB_IDLE),
        .done_o     (lat_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            starve_q     <= '0;
            mem_we_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (if_win) begin
                        state_q <= ARB_BUSY_IF;
                    end else if (mem_win) begin
                        state_q  <= ARB_BUSY_MEM;
                        mem_we_q <= mem_we_i;
                    end
                end
                ARB_BUSY_IF: begin
                    if (lat_done) begin
                        state_q     <= ARB_IDLE;
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= ram_rdata_i;
                    end
                end
                ARB_BUSY_MEM: begin
                    if (lat_done) begin
                        state_q      <= ARB_IDLE;
                        mem_rvalid_q <= 1'b1;
                        // A write only acknowledges; load data keeps its value.
                        if (!mem_we_q) begin
                            mem_rdata_q <= ram_rdata_i;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase

            // Count IF losses; never exceeds STARVE_LIM since IF then wins.
            if (if_win) begin
                starve_q <= '0;
            end else if (mem_win && if_req_i && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + ARB_STARVE_W'(1);
            end
        end
    end

    assign if_gnt_o       = if_win;
    assign mem_gnt_o      = mem_win;
    assign if_rvalid_o    = if_rvalid_q;
    assign mem_rvalid_o   = mem_rvalid_q;
    assign if_rdata_o     = if_rdata_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign stallreq_if_o  = if_req_i  & ~if_rvalid_q;
    assign stallreq_mem_o = mem_req_i & ~mem_rvalid_q;
    assign dbg_state_o    = state_q;

`ifdef MEM_PORT_ARB_PERF_CNT_EN
    logic [31:0] if_grant_cnt_q;
    logic [31:0] mem_grant_cnt_q;
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_grant_cnt_q  <= '0;
            mem_grant_cnt_q <= '0;
            conflict_cnt_q  <= '0;
        end else begin
            if (if_win)  if_grant_cnt_q  <= if_grant_cnt_q + 32'd1;
            if (mem_win) mem_grant_cnt_q <= mem_grant_cnt_q + 32'd1;
            if ((state_q == ARB_IDLE) && if_req_i && mem_req_i) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign if_grant_cnt_o  = if_grant_cnt_q;
    assign mem_grant_cnt_o = mem_grant_cnt_q;
    assign conflict_cnt_o  = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (RAM_LATENCY=2, STARVE_LIMIT=3).
//   A behavioural RAM returns read data two cycles after each command.
//   Stimulus pushes expected response data and cycle into per-port queues;
//   a negedge monitor pops and compares on every rvalid pulse.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [3:0]  mem_be_i = 4'h0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic        mem_gnt_o, mem_rvalid_o;
  logic [31:0] mem_rdata_o;
  logic        ram_ce_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        stallreq_if_o, stallreq_mem_o;
  arb_state_e  dbg_state_o;
`ifdef MEM_PORT_ARB_PERF_CNT_EN
  logic [31:0] if_grant_cnt_o, mem_grant_cnt_o, conflict_cnt_o;
`endif

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(2), .STARVE_LIMIT(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_gnt_o(mem_gnt_o),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .dbg_state_o(dbg_state_o)
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    , .if_grant_cnt_o(if_grant_cnt_o), .mem_grant_cnt_o(mem_grant_cnt_o),
    .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  // ---------------- behavioural RAM (latency 2) ----------------
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] rd0 = '0, rd1 = '0, ram_word;
  assign ram_rdata_i = rd1;

  always @(posedge clk_i) begin
    rd1 <= rd0;
    if (ram_ce_o) begin
      ram_word = ram_mem.exists(ram_addr_o) ? ram_mem[ram_addr_o] : 32'h0;
      rd0 <= ram_word;
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_word[8*b +: 8] = ram_wdata_o[8*b +: 8];
        ram_mem[ram_addr_o] = ram_word;
      end
    end else begin
      rd0 <= 32'h0;
    end
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_if_q[$];
  int          exp_if_cyc_q[$];
  logic [31:0] exp_mem_q[$];
  int          exp_mem_cyc_q[$];
  logic [31:0] mon_if_d, mon_mem_d;
  int          mon_if_c, mon_mem_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (if_rvalid_o) begin
      if (exp_if_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL if_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_if_d = exp_if_q.pop_front();
        mon_if_c = exp_if_cyc_q.pop_front();
        chk("if_rdata", if_rdata_o, mon_if_d);
        chk("if_rvalid_cycle", cyc, mon_if_c);
      end
    end
    if (mem_rvalid_o) begin
      if (exp_mem_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL mem_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_mem_d = exp_mem_q.pop_front();
        mon_mem_c = exp_mem_cyc_q.pop_front();
        chk("mem_rdata", mem_rdata_o, mon_mem_d);
        chk("mem_rvalid_cycle", cyc, mon_mem_c);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_if(input logic [31:0] d, input int c);
    exp_if_q.push_back(d);
    exp_if_cyc_q.push_back(c);
  endtask

  task automatic push_mem(input logic [31:0] d, input int c);
    exp_mem_q.push_back(d);
    exp_mem_cyc_q.push_back(c);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_be_i = 4'h0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},     32'(if_gnt_o), 0);
    chk({tag, "_mem_gnt"},    32'(mem_gnt_o), 0);
    chk({tag, "_if_rvalid"},  32'(if_rvalid_o), 0);
    chk({tag, "_mem_rvalid"}, 32'(mem_rvalid_o), 0);
    chk({tag, "_if_rdata"},   if_rdata_o, 0);
    chk({tag, "_mem_rdata"},  mem_rdata_o, 0);
    chk({tag, "_ram_ce"},     32'(ram_ce_o), 0);
    chk({tag, "_ram_we"},     32'(ram_we_o), 0);
    chk({tag, "_ram_be"},     32'(ram_be_o), 0);
    chk({tag, "_ram_addr"},   ram_addr_o, 0);
    chk({tag, "_ram_wdata"},  ram_wdata_o, 0);
    chk({tag, "_stall_if"},   32'(stallreq_if_o), 0);
    chk({tag, "_stall_mem"},  32'(stallreq_mem_o), 0);
    chk({tag, "_state"},      32'(dbg_state_o), 0);
  endtask

  // ---------------- stimulus ----------------
  int c0;
  logic exp_mg, exp_ig;

  initial begin
    ram_mem[32'h0000_0100] = 32'h0000_0013;
    ram_mem[32'h0000_0104] = 32'h0000_0093;
    ram_mem[32'h0000_0108] = 32'h00A0_0113;
    ram_mem[32'h0000_2000] = 32'hCAFE_0001;
    ram_mem[32'h0000_2004] = 32'h5566_7788;

    do_reset();
    chk_all_zero("reset");

    // Lone IF read
    if_req_i = 1'b1; if_addr_i = 32'h100; c0 = cyc;
    push_if(32'h0000_0013, c0 + 3);
    #1;
    chk("lone_if_gnt", 32'(if_gnt_o), 1);
    chk("lone_ram_ce", 32'(ram_ce_o), 1);
    chk("lone_ram_addr", ram_addr_o, 32'h100);
    chk("lone_mem_gnt", 32'(mem_gnt_o), 0);
    chk("lone_stall_c0", 32'(stallreq_if_o), 1);
    tick();
    chk("lone_if_gnt_c1", 32'(if_gnt_o), 0);
    chk("lone_ram_ce_c1", 32'(ram_ce_o), 0);
    chk("lone_stall_c1", 32'(stallreq_if_o), 1);
    chk("lone_state_c1", 32'(dbg_state_o), 1);
    tick();
    chk("lone_stall_c2", 32'(stallreq_if_o), 1);
    tick();
    chk("lone_rvalid_c3", 32'(if_rvalid_o), 1);
    chk("lone_stall_c3", 32'(stallreq_if_o), 0);
    if_req_i = 1'b0;
    tick();
    chk("lone_rvalid_c4", 32'(if_rvalid_o), 0);
    chk("lone_rdata_hold", if_rdata_o, 32'h0000_0013);
    tick();

    // Contention: MEM first, IF at MEM's rvalid cycle
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h104;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_be_i = 4'hF; mem_addr_i = 32'h2000;
    c0 = cyc;
    push_mem(32'hCAFE_0001, c0 + 3);
    push_if(32'h0000_0093, c0 + 6);
    #1;
    chk("cont_mem_gnt", 32'(mem_gnt_o), 1);
    chk("cont_if_gnt", 32'(if_gnt_o), 0);
    chk("cont_ram_addr", ram_addr_o, 32'h2000);
    chk("cont_stall_if", 32'(stallreq_if_o), 1);
    repeat (3) tick();
    chk("cont_stall_mem_c3", 32'(stallreq_mem_o), 0);
    mem_req_i = 1'b0;
    #1;
    chk("cont_if_gnt_c3", 32'(if_gnt_o), 1);
    chk("cont_ram_addr_c3", ram_addr_o, 32'h104);
    chk("cont_mem_gnt_c3", 32'(mem_gnt_o), 0);
    repeat (3) tick();
    if_req_i = 1'b0;
    tick();
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    chk("perf_if_grants", if_grant_cnt_o, 1);
    chk("perf_mem_grants", mem_grant_cnt_o, 1);
    chk("perf_conflicts", conflict_cnt_o, 1);
`endif

    // MEM write (bytes 0,1) then read-back
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_be_i = 4'b0011;
    mem_addr_i = 32'h2004; mem_wdata_i = 32'hDEAD_BEEF; c0 = cyc;
    push_mem(32'hCAFE_0001, c0 + 3);
    #1;
    chk("wr_mem_gnt", 32'(mem_gnt_o), 1);
    chk("wr_ram_we", 32'(ram_we_o), 1);
    chk("wr_ram_be", 32'(ram_be_o), 32'h3);
    chk("wr_ram_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    chk("wr_ram_addr", ram_addr_o, 32'h2004);
    repeat (3) tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_be_i = 4'h0;
    tick();
    mem_req_i = 1'b1; mem_be_i = 4'hF; c0 = cyc;
    push_mem(32'h5566_BEEF, c0 + 3);
    #1;
    chk("rd_ram_we", 32'(ram_we_o), 0);
    repeat (3) tick();
    mem_req_i = 1'b0;
    tick();

    // Starvation: MEM wins 3 times, IF the 4th, then counter cleared
    if_req_i = 1'b1; if_addr_i = 32'h108;
    mem_req_i = 1'b1; mem_addr_i = 32'h2000; c0 = cyc;
    push_mem(32'hCAFE_0001, c0 + 3);
    push_mem(32'hCAFE_0001, c0 + 6);
    push_mem(32'hCAFE_0001, c0 + 9);
    push_if(32'h00A0_0113, c0 + 12);
    push_mem(32'hCAFE_0001, c0 + 15);
    push_if(32'h00A0_0113, c0 + 18);
    for (int off = 0; off <= 18; off++) begin
      if (off == 15) mem_req_i = 1'b0;
      if (off == 18) if_req_i = 1'b0;
      #1;
      exp_mg = (off == 0) || (off == 3) || (off == 6) || (off == 12);
      exp_ig = (off == 9) || (off == 15);
      chk($sformatf("starve_mem_gnt_%0d", off), 32'(mem_gnt_o), 32'(exp_mg));
      chk($sformatf("starve_if_gnt_%0d", off), 32'(if_gnt_o), 32'(exp_ig));
      tick();
    end
    tick();

    // Reset in the cycle after an IF grant
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1;
    chk("rst_if_gnt", 32'(if_gnt_o), 1);
    tick();
    rst_i = 1'b1; if_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (6) tick();

    chk("if_queue_drained", 32'(exp_if_q.size()), 0);
    chk("mem_queue_drained", 32'(exp_mem_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
